// File: rtl/uart_pkg.sv
// Shared UART definitions: packet-controller state encoding, sync byte and
// receiver defaults.
package uart_pkg;

    localparam int unsigned SIZE_DATA_DEF   = 8;
    localparam int unsigned OVER_SAMPLE_DEF = 16;

    localparam logic [7:0] UART_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DRAIN   = 3'd4
    } rx_pkt_state_t;

endpackage

// File: rtl/rx_pkt_buffer.sv
// Payload store: flop array, synchronous write, combinational read,
// cleared by synchronous reset.
module rx_pkt_buffer #(
    parameter int unsigned SIZE_DATA = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wr_en,
    input  logic [ADDR_W-1:0]    i_wr_addr,
    input  logic [SIZE_DATA-1:0] i_wr_data,
    input  logic [ADDR_W-1:0]    i_rd_addr,
    output logic [SIZE_DATA-1:0] o_rd_data
);

    logic [SIZE_DATA-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mem <= '{default: '0};
        end else if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames receiver bytes as sync/length/payload/checksum, verifies the packet
// and streams the payload to the decoder over valid/ready.
module uart_rx_pkt_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned SIZE_DATA     = SIZE_DATA_DEF,
    parameter int unsigned MAX_LEN       = 16,
    parameter int unsigned TIMEOUT_TICKS = 160
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_stick,
    input  logic                 i_rx_done,
    input  logic [SIZE_DATA-1:0] i_rx_data,
    output logic                 o_rx_en,
    output logic                 o_fifo_full,
    output logic [SIZE_DATA-1:0] o_pkt_data,
    output logic                 o_pkt_valid,
    input  logic                 i_pkt_ready,
    output logic                 o_pkt_last,
    output logic [7:0]           o_pkt_len,
    output logic                 o_err_len,
    output logic                 o_err_chk,
    output logic                 o_err_tmo,
    output logic                 o_err_ovf
);

    localparam int unsigned PTR_W  = $clog2(MAX_LEN + 1);
    localparam int unsigned BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_TICKS + 1);

    rx_pkt_state_t        state;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [SIZE_DATA-1:0] acc;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [7:0]           pkt_len;
    logic [SIZE_DATA-1:0] rd_data;
    logic                 tmo_active;
    logic                 tmo_hit;
    logic                 rd_last;
    logic                 len_ok;
    logic                 buf_wr;

    // A byte arriving on the terminal tick takes priority over the timeout.
    assign tmo_active = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
    assign tmo_hit    = tmo_active && i_stick && !i_rx_done &&
                        (tmo_cnt == TMO_W'(TIMEOUT_TICKS - 1));
    assign rd_last    = (8'(rd_ptr) + 8'd1) == pkt_len;
    assign len_ok     = (i_rx_data != '0) && (i_rx_data <= SIZE_DATA'(MAX_LEN));
    assign buf_wr     = (state == ST_PAYLOAD) && i_rx_done;

    rx_pkt_buffer #(
        .SIZE_DATA (SIZE_DATA),
        .DEPTH     (MAX_LEN),
        .ADDR_W    (BUF_AW)
    ) u_buf (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (buf_wr),
        .i_wr_addr (wr_ptr[BUF_AW-1:0]),
        .i_wr_data (i_rx_data),
        .i_rd_addr (rd_ptr[BUF_AW-1:0]),
        .o_rd_data (rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_HUNT;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            acc       <= '0;
            tmo_cnt   <= '0;
            pkt_len   <= '0;
            o_rx_en   <= 1'b0;
            o_err_len <= 1'b0;
            o_err_chk <= 1'b0;
            o_err_tmo <= 1'b0;
            o_err_ovf <= 1'b0;
        end else begin
            o_rx_en   <= 1'b1;
            o_err_len <= 1'b0;
            o_err_chk <= 1'b0;
            o_err_tmo <= 1'b0;
            o_err_ovf <= 1'b0;

            // Inter-byte watchdog, saturating.
            if (!tmo_active || i_rx_done || tmo_hit) begin
                tmo_cnt <= '0;
            end else if (i_stick && (tmo_cnt != TMO_W'(TIMEOUT_TICKS))) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            case (state)
                ST_HUNT: begin
                    if (i_rx_done && (i_rx_data == SIZE_DATA'(UART_SYNC_BYTE))) begin
                        state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (i_rx_done) begin
                        if (len_ok) begin
                            pkt_len <= 8'(i_rx_data);
                            wr_ptr  <= '0;
                            acc     <= '0;
                            state   <= ST_PAYLOAD;
                        end else begin
                            o_err_len <= 1'b1;
                            state     <= ST_HUNT;
                        end
                    end else if (tmo_hit) begin
                        o_err_tmo <= 1'b1;
                        state     <= ST_HUNT;
                    end
                end
                ST_PAYLOAD: begin
                    if (i_rx_done) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                        acc    <= acc ^ i_rx_data;
                        if ((8'(wr_ptr) + 8'd1) == pkt_len) begin
                            state <= ST_CHK;
                        end
                    end else if (tmo_hit) begin
                        o_err_tmo <= 1'b1;
                        state     <= ST_HUNT;
                    end
                end
                ST_CHK: begin
                    if (i_rx_done) begin
                        if (i_rx_data == acc) begin
                            rd_ptr  <= '0;
                            o_rx_en <= 1'b0;
                            state   <= ST_DRAIN;
                        end else begin
                            o_err_chk <= 1'b1;
                            state     <= ST_HUNT;
                        end
                    end else if (tmo_hit) begin
                        o_err_tmo <= 1'b1;
                        state     <= ST_HUNT;
                    end
                end
                ST_DRAIN: begin
                    o_err_ovf <= i_rx_done;
                    if (i_pkt_ready && rd_last) begin
                        rd_ptr <= '0;
                        state  <= ST_HUNT;
                    end else begin
                        o_rx_en <= 1'b0;
                        if (i_pkt_ready) begin
                            rd_ptr <= rd_ptr + PTR_W'(1);
                        end
                    end
                end
                default: state <= ST_HUNT;
            endcase
        end
    end

    assign o_pkt_valid = (state == ST_DRAIN);
    assign o_pkt_data  = o_pkt_valid ? rd_data : '0;
    assign o_pkt_last  = o_pkt_valid && rd_last;
    assign o_pkt_len   = pkt_len;
    assign o_fifo_full = ~o_rx_en;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl with a payload scoreboard.
module tb_uart_rx_pkt_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_stick;
    logic       i_rx_done;
    logic [7:0] i_rx_data;
    logic       o_rx_en;
    logic       o_fifo_full;
    logic [7:0] o_pkt_data;
    logic       o_pkt_valid;
    logic       i_pkt_ready;
    logic       o_pkt_last;
    logic [7:0] o_pkt_len;
    logic       o_err_len;
    logic       o_err_chk;
    logic       o_err_tmo;
    logic       o_err_ovf;

    int checks = 0;
    int errors = 0;
    int n_len = 0, n_chk = 0, n_tmo = 0, n_ovf = 0;
    int n_valid = 0, n_rxen_low = 0;

    logic [7:0] exp_q [$];
    logic [7:0] stim_q [$];

    logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
    logic [7:0] prev_data = '0;

    uart_rx_pkt_ctrl #(
        .SIZE_DATA     (8),
        .MAX_LEN       (16),
        .TIMEOUT_TICKS (160)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_stick     (i_stick),
        .i_rx_done   (i_rx_done),
        .i_rx_data   (i_rx_data),
        .o_rx_en     (o_rx_en),
        .o_fifo_full (o_fifo_full),
        .o_pkt_data  (o_pkt_data),
        .o_pkt_valid (o_pkt_valid),
        .i_pkt_ready (i_pkt_ready),
        .o_pkt_last  (o_pkt_last),
        .o_pkt_len   (o_pkt_len),
        .o_err_len   (o_err_len),
        .o_err_chk   (o_err_chk),
        .o_err_tmo   (o_err_tmo),
        .o_err_ovf   (o_err_ovf)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and pulse/occupancy counters, sampled away from the clock edge.
    always @(negedge i_clk) begin
        logic [7:0] exp_b;
        logic       exp_last;
        if (!i_rst) begin
            if (o_err_len) n_len++;
            if (o_err_chk) n_chk++;
            if (o_err_tmo) n_tmo++;
            if (o_err_ovf) n_ovf++;
            if (o_pkt_valid) n_valid++;
            if (!o_rx_en) n_rxen_low++;
            if (o_pkt_valid && prev_valid && !prev_ready) begin
                check("stall_data", 32'(o_pkt_data), 32'(prev_data));
                check("stall_last", 32'(o_pkt_last), 32'(prev_last));
            end
            if (o_pkt_valid && i_pkt_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte_qsize", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_last = (exp_q.size() == 1);
                    exp_b    = exp_q.pop_front();
                    check("pkt_data", 32'(o_pkt_data), 32'(exp_b));
                    check("pkt_last", 32'(o_pkt_last), 32'(exp_last));
                end
            end
        end
        prev_valid = o_pkt_valid;
        prev_ready = i_pkt_ready;
        prev_data  = o_pkt_data;
        prev_last  = o_pkt_last;
    end

    task automatic send_byte(input logic [7:0] b);
        i_rx_done = 1'b1;
        i_rx_data = b;
        @(posedge i_clk); #1;
        i_rx_done = 1'b0;
    endtask

    task automatic send_stim();
        while (stim_q.size() > 0) send_byte(stim_q.pop_front());
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            i_stick = 1'b1;
            @(posedge i_clk); #1;
            i_stick = 1'b0;
            @(posedge i_clk); #1;
        end
    endtask

    // Waits for the queued payload to drain; mode 1 stalls ready in a 1,0,0 pattern.
    task automatic drain(input int mode);
        int k = 0;
        while ((exp_q.size() != 0 || o_pkt_valid) && k < 200) begin
            i_pkt_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            @(posedge i_clk); #1;
            k++;
        end
        i_pkt_ready = 1'b1;
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_valid_low", 32'(o_pkt_valid), 32'd0);
    endtask

    initial begin
        i_rst = 1'b1; i_stick = 1'b0; i_rx_done = 1'b0; i_rx_data = '0; i_pkt_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_rx_en", 32'(o_rx_en), 32'd0);
        check("rst_fifo_full", 32'(o_fifo_full), 32'd1);
        check("rst_valid", 32'(o_pkt_valid), 32'd0);
        check("rst_last", 32'(o_pkt_last), 32'd0);
        check("rst_data", 32'(o_pkt_data), 32'd0);
        check("rst_len", 32'(o_pkt_len), 32'd0);
        check("rst_errs", 32'({o_err_len, o_err_chk, o_err_tmo, o_err_ovf}), 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        check("rel_rx_en", 32'(o_rx_en), 32'd1);
        check("rel_fifo_full", 32'(o_fifo_full), 32'd0);

        // Good packet at full rate.
        n_rxen_low = 0; n_valid = 0;
        stim_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h44, 8'h77};
        exp_q  = '{8'h11, 8'h22, 8'h44};
        send_stim();
        check("good_first_valid", 32'(o_pkt_valid), 32'd1);
        check("good_first_data", 32'(o_pkt_data), 32'h11);
        check("good_len", 32'(o_pkt_len), 32'd3);
        check("good_fifo_full", 32'(o_fifo_full), 32'd1);
        drain(0);
        check("good_valid_cycles", 32'(n_valid), 32'd3);
        check("good_rxen_low", 32'(n_rxen_low), 32'd3);
        check("good_rx_en_back", 32'(o_rx_en), 32'd1);
        check("good_no_err", 32'(n_len + n_chk + n_tmo + n_ovf), 32'd0);

        // Same packet under backpressure.
        stim_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h44, 8'h77};
        exp_q  = '{8'h11, 8'h22, 8'h44};
        send_stim();
        drain(1);

        // Length errors, then a one-byte packet.
        send_byte(8'hA5);
        send_byte(8'h00);
        check("len0_pulse", 32'(o_err_len), 32'd1);
        @(posedge i_clk); #1;
        check("len0_pulse_end", 32'(o_err_len), 32'd0);
        send_byte(8'hA5);
        send_byte(8'h11);
        check("len17_pulse", 32'(o_err_len), 32'd1);
        @(posedge i_clk); #1;
        check("len_err_count", 32'(n_len), 32'd2);
        stim_q = '{8'hA5, 8'h01, 8'h5A, 8'h5A};
        exp_q  = '{8'h5A};
        send_stim();
        check("len1_len", 32'(o_pkt_len), 32'd1);
        check("len1_last", 32'(o_pkt_last), 32'd1);
        drain(0);

        // Checksum error: nothing may stream.
        n_valid = 0;
        stim_q = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h00};
        send_stim();
        check("chk_pulse", 32'(o_err_chk), 32'd1);
        repeat (4) @(posedge i_clk);
        #1;
        check("chk_count", 32'(n_chk), 32'd1);
        check("chk_no_valid", 32'(n_valid), 32'd0);

        // Timeout after 160 silent ticks.
        stim_q = '{8'hA5, 8'h02, 8'h01};
        send_stim();
        ticks(159);
        check("tmo_not_yet", 32'(n_tmo), 32'd0);
        ticks(1);
        check("tmo_once", 32'(n_tmo), 32'd1);

        // Byte on the terminal tick wins.
        stim_q = '{8'hA5, 8'h02, 8'h01};
        send_stim();
        ticks(159);
        exp_q = '{8'h01, 8'h02};
        i_stick = 1'b1;
        send_byte(8'h02);
        i_stick = 1'b0;
        send_byte(8'h03);
        drain(0);
        check("tmo_byte_wins", 32'(n_tmo), 32'd1);

        // Overflow while stalled, then reset mid-drain.
        i_pkt_ready = 1'b0;
        stim_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h44, 8'h77};
        exp_q  = '{8'h11, 8'h22, 8'h44};
        send_stim();
        send_byte(8'h99);
        check("ovf_pulse", 32'(o_err_ovf), 32'd1);
        i_pkt_ready = 1'b1;
        @(posedge i_clk); #1;
        i_pkt_ready = 1'b0;
        check("mid_left", 32'(exp_q.size()), 32'd2);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        check("mid_rst_valid", 32'(o_pkt_valid), 32'd0);
        check("mid_rst_rx_en", 32'(o_rx_en), 32'd0);
        check("mid_rst_data", 32'(o_pkt_data), 32'd0);
        check("mid_rst_len", 32'(o_pkt_len), 32'd0);
        exp_q.delete();
        i_rst = 1'b0;
        i_pkt_ready = 1'b1;
        @(posedge i_clk); #1;
        stim_q = '{8'hA5, 8'h03, 8'hC3, 8'h3C, 8'h0F, 8'hF0};
        exp_q  = '{8'hC3, 8'h3C, 8'h0F};
        send_stim();
        check("post_rst_len", 32'(o_pkt_len), 32'd3);
        drain(0);
        check("ovf_count", 32'(n_ovf), 32'd1);
        check("final_err_counts", 32'({8'(n_len), 8'(n_chk), 8'(n_tmo)}), 32'h020101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
